// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: S-stage shift/rotate pipeline, stage k moves by 2^k, with a global valid/ready stall
module pipelined_barrel_shifter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] amt,
  input  logic [2:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         y,
  output logic                 cout
);
  localparam int S = $clog2(N);
  logic advance;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int SH = 1 << k;
    logic           vi, ci, c_d, v_q, c_q;
    logic [N-1:0]   di, sra, r_d, r_q;
    logic [S-k-1:0] ai;
    logic [2:0]     mi;
    if (k == 0) begin : g_first
      assign vi = in_valid;
      assign di = a;
      assign ai = amt;
      assign mi = mode;
      assign ci = 1'b0;
    end else begin : g_next
      assign vi = g_st[k-1].v_q;
      assign di = g_st[k-1].r_q;
      assign ai = g_st[k-1].g_fw.a_q;
      assign mi = g_st[k-1].g_fw.m_q;
      assign ci = g_st[k-1].c_q;
    end
    // SRA keeps the MSB at every stage, so the partial result's top bit is always the original sign
    assign sra = $signed(di) >>> SH;
    always_comb begin
      r_d = !ai[0]       ? di :
            mi == 3'd0   ? di >> SH :
            mi == 3'd1   ? di << SH :
            mi == 3'd2   ? sra :
            mi == 3'd3   ? (di >> SH) | (di << (N - SH)) :
            mi == 3'd4   ? (di << SH) | (di >> (N - SH)) : di;
      c_d = !ai[0]                    ? ci :
            mi == 3'd0 || mi == 3'd2  ? di[SH-1] :
            mi == 3'd1                ? di[N-SH] : 1'b0;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        r_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= vi;
        r_q <= r_d;
        c_q <= c_d;
      end
    end
    // Only the not-yet-consumed amt bits and the mode travel forward
    if (k < S - 1) begin : g_fw
      logic [S-k-2:0] a_q;
      logic [2:0]     m_q;
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= ai[S-k-1:1];
          m_q <= mi;
        end
      end
    end
  end
  assign out_valid = g_st[S-1].v_q;
  assign y         = g_st[S-1].r_q;
  assign cout      = g_st[S-1].c_q;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vector table plus stream, stall, reset and sweep sequences
module tb_pipelined_barrel_shifter;
  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [2:0] amt = '0, mode = '0;
  logic       in_ready, out_valid, cout;
  logic [7:0] y;

  pipelined_barrel_shifter #(.N(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amt(amt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [2:0] amt;
    logic [2:0] mode;
    logic [7:0] y;
    logic       c;
  } vec_t;
  typedef struct {
    logic [8:0] e;
    int         t;
  } exp_t;

  exp_t q[$];
  vec_t tv[16];
  int   tests = 0, fails = 0, cnt = 0, nout = 0;
  bit   nostall = 1'b1;

  // One-bit-at-a-time reference: shift amt times, remembering the last bit to fall off
  function automatic logic [8:0] ref_m(input logic [7:0] x, input logic [2:0] s, input logic [2:0] m);
    logic [7:0] r;
    logic       c;
    r = x;
    c = 1'b0;
    for (int i = 0; i < int'(s); i++) begin
      case (m)
        3'd0: begin c = r[0]; r = {1'b0, r[7:1]}; end
        3'd1: begin c = r[7]; r = {r[6:0], 1'b0}; end
        3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
        3'd3: r = {r[0], r[7:1]};
        3'd4: r = {r[6:0], r[7]};
        default: ;
      endcase
    end
    return {c, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [7:0] ia, input logic [2:0] iamt,
                     input logic [2:0] im, input logic ordy, input logic [8:0] ex);
    in_valid = iv; a = ia; amt = iamt; mode = im; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_output: got y=%0h cout=%0b expected no output", y, cout);
      end else begin
        chk("y", {24'd0, y}, {24'd0, q[0].e[7:0]});
        chk("cout", {31'd0, cout}, {31'd0, q[0].e[8]});
        if (nostall) chk("latency", cnt - q[0].t, 3);
        void'(q.pop_front());
        nout++;
      end
    end
    if (in_valid && in_ready) q.push_back('{e: ex, t: cnt});
    cnt++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 9'd0);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hy;
    logic       hc;
    logic [7:0] ra;
    logic [2:0] rs, rm;
    int         n0;
    tv[0]  = '{8'hB2, 3'd3, 3'd0, 8'h16, 1'b0};
    tv[1]  = '{8'hB2, 3'd3, 3'd2, 8'hF6, 1'b0};
    tv[2]  = '{8'hB2, 3'd3, 3'd3, 8'h56, 1'b0};
    tv[3]  = '{8'hB2, 3'd3, 3'd4, 8'h95, 1'b0};
    tv[4]  = '{8'hB2, 3'd3, 3'd1, 8'h90, 1'b1};
    tv[5]  = '{8'hFF, 3'd7, 3'd0, 8'h01, 1'b1};
    tv[6]  = '{8'h80, 3'd7, 3'd2, 8'hFF, 1'b0};
    tv[7]  = '{8'h01, 3'd7, 3'd1, 8'h80, 1'b0};
    tv[8]  = '{8'hC3, 3'd0, 3'd4, 8'hC3, 1'b0};
    tv[9]  = '{8'h5A, 3'd5, 3'd7, 8'h5A, 1'b0};
    tv[10] = '{8'h81, 3'd1, 3'd3, 8'hC0, 1'b0};
    tv[11] = '{8'h81, 3'd1, 3'd1, 8'h02, 1'b1};
    tv[12] = '{8'h81, 3'd1, 3'd0, 8'h40, 1'b1};
    tv[13] = '{8'h81, 3'd4, 3'd5, 8'h81, 1'b0};
    tv[14] = '{8'h81, 3'd2, 3'd6, 8'h81, 1'b0};
    tv[15] = '{8'hB2, 3'd0, 3'd2, 8'hB2, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_y", {24'd0, y}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);

    // Isolated directed vectors, each checked for value and 3-cycle latency
    foreach (tv[i]) begin
      cyc(1'b1, tv[i].a, tv[i].amt, tv[i].mode, 1'b1, {tv[i].c, tv[i].y});
      drain();
    end

    // Back-to-back random stream
    n0 = nout;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      rm = 3'($urandom_range(0, 7));
      cyc(1'b1, ra, rs, rm, 1'b1, ref_m(ra, rs, rm));
    end
    drain();
    chk("stream_count", nout - n0, 16);

    // Exhaustive amt x mode sweep on 8'h81
    for (int m = 0; m < 8; m++)
      for (int s = 0; s < 8; s++)
        cyc(1'b1, 8'h81, 3'(s), 3'(m), 1'b1, ref_m(8'h81, 3'(s), 3'(m)));
    drain();

    // Fill the pipe with the consumer stalled, hold 5 cycles, then release
    nostall = 1'b0;
    n0 = nout;
    for (int i = 0; i < 3; i++) cyc(1'b1, tv[i].a, tv[i].amt, tv[i].mode, 1'b0, {tv[i].c, tv[i].y});
    chk("stall_full", {31'd0, out_valid}, 1);
    hy = y;
    hc = cout;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hEE, 3'd1, 3'd0, 1'b0, 9'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      chk("stall_out_valid", {31'd0, out_valid}, 1);
      chk("stall_y", {24'd0, y}, {24'd0, hy});
      chk("stall_cout", {31'd0, cout}, {31'd0, hc});
    end
    drain();
    chk("stall_count", nout - n0, 3);
    cyc(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 9'd0);
    chk("stall_no_dup", {31'd0, out_valid}, 0);
    nostall = 1'b1;

    // Reset with two items in flight and a third presented in the reset cycle
    cyc(1'b1, 8'h12, 3'd2, 3'd0, 1'b1, ref_m(8'h12, 3'd2, 3'd0));
    cyc(1'b1, 8'h34, 3'd1, 3'd1, 1'b1, ref_m(8'h34, 3'd1, 3'd1));
    reset = 1'b1;
    in_valid = 1'b1;
    a = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    q.delete();
    @(negedge clk);
    n0 = nout;
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, 9'd0);
    chk("reset_discard", nout - n0, 0);
    cyc(1'b1, tv[4].a, tv[4].amt, tv[4].mode, 1'b1, {tv[4].c, tv[4].y});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter N, default 8: data width; power of two, N >= 4.
REQ-002 The block SHALL have derived localparam S = $clog2(N): the number of shift stages and the pipeline depth.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high clear.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-008 The block SHALL have port a, input, N bits: the operand.
REQ-009 The block SHALL have port amt, input, S bits: the shift distance, 0..N-1.
REQ-010 The block SHALL have port mode, input, 3 bits: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL; 101-111 pass-through.
REQ-011 The block SHALL have port out_valid, output, 1 bit: y and cout are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port y, output, N bits: the shifted result.
REQ-014 The block SHALL have port cout, output, 1 bit: the last bit shifted out.

Function
REQ-015 The block SHALL implement S pipeline stages; stage k conditionally shifts or rotates by 2^k when amt bit k is 1; stage k is registered.
REQ-016 A transfer SHALL occur on a rising edge with in_valid && in_ready (input side) or out_valid && out_ready (output side).
REQ-017 The pipeline SHALL stall globally: advance = !out_valid || out_ready; in_ready = advance (combinational, no dependence on in_valid).
REQ-018 The latency SHALL be exactly S cycles from an accepted input to out_valid when there is no stall; throughput SHALL be one result per cycle under continuous out_ready.
REQ-019 Every stage SHALL carry a valid bit, the remaining amt bits, mode, a partial result, and a cout bit; a bubble (in_valid=0 when advance=1) SHALL propagate as valid=0.
REQ-020 While advance=0, all stage registers, y, cout and out_valid SHALL hold unchanged; bubbles are not compressed.
REQ-021 SRL SHALL zero-fill at the MSB side; SLL SHALL zero-fill at the LSB side; SRA SHALL fill with the original a[N-1]; ROR/ROL SHALL recirculate bits.
REQ-022 cout SHALL be the last bit shifted out for SRL/SLL/SRA: SRL/SRA give a[amt-1], SLL gives a[N-amt]; cout SHALL be 0 when amt=0, for rotates, and for pass-through.
REQ-023 Pass-through modes SHALL give y = a, ignoring amt.
REQ-024 The result SHALL depend only on the a, amt and mode sampled at acceptance; later input changes SHALL NOT affect in-flight items.
REQ-025 amt=0 SHALL give y = a for every mode.

Reset
REQ-026 On reset=1 at a rising edge, all stage valid bits and out_valid SHALL clear to 0, and y and cout SHALL clear to 0.
REQ-027 In-flight items SHALL be discarded on reset mid-operation; no result SHALL emerge from data accepted before reset.
REQ-028 in_ready SHALL be 1 in the cycle after reset deasserts, because out_valid=0.
REQ-029 Reset SHALL take priority over a simultaneous transfer; data presented in the reset cycle SHALL NOT be accepted.

Verification (N=8, S=3)
REQ-030 Scenario 1: a=8'b1011_0010, amt=3, mode=SRL, out_ready=1 -> 3 cycles later out_valid=1, y=8'b0001_0110, cout=0.
REQ-031 Scenario 2: the same a with mode SRA, ROR, ROL and SLL (amt=3) -> y=8'b1111_0110, 8'b0101_0110, 8'b1001_0101, 8'b1001_0000; SLL cout=1.
REQ-032 Scenario 3: back-to-back stream of 16 random operands with out_ready=1 -> 16 consecutive out_valid cycles, results in order, matching the reference model.
REQ-033 Scenario 4: out_ready=0 held 5 cycles with a full pipeline -> in_ready=0, y/cout/out_valid stable; on out_ready=1, no loss and no duplication.
REQ-034 Scenario 5: reset asserted while 2 items are in flight -> out_valid=0 on the next cycle and neither item ever appears.
REQ-035 Scenario 6: exhaustive sweep of amt 0..7 over all 8 mode codes for a=8'h81 -> matches the model; modes 101-111 give y=8'h81, cout=0.
